// File: rtl/secuenciador_trabajos.sv
// Job sequencer: queues hash jobs, resets and runs the core per job, scores the result.
// Latency fin->res_valid 1 cycle; job_ready = !full (low in reset); REPORT holds until res_ready.
module secuenciador_trabajos_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  // Generic show-ahead FIFO: head is visible on dout whenever not empty.
  // Zero-cycle read latency; pushes while full and pops while empty are dropped.
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end
endmodule

module secuenciador_trabajos #(
  parameter int NONCE_W  = 32,
  parameter int BOUNTY_W = 24,
  parameter int TARGET_W = 8,
  parameter int NUM_W    = 2,
  parameter int DEPTH    = 4,
  parameter int RST_CYC  = 4,
  parameter int TIMEOUT  = 4096,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                job_valid,
  output logic                job_ready,
  input  logic [NUM_W-1:0]    job_num,
  input  logic [TARGET_W-1:0] job_target,
  input  logic [NONCE_W-1:0]  job_nonce_exp,
  output logic                dut_reset_L,
  output logic [NUM_W-1:0]    num_entradas,
  output logic [TARGET_W-1:0] target,
  input  logic                fin,
  input  logic [NONCE_W-1:0]  nonce_valido_out,
  input  logic [BOUNTY_W-1:0] bounty_out,
  output logic                res_valid,
  input  logic                res_ready,
  output logic                res_pass,
  output logic                res_timeout,
  output logic [NONCE_W-1:0]  res_nonce,
  output logic [BOUNTY_W-1:0] res_bounty,
  output logic [CNT_W-1:0]    pass_cnt,
  output logic [CNT_W-1:0]    fail_cnt,
  output logic                idle
);
  localparam int ENT_W   = NUM_W + TARGET_W + NONCE_W;
  localparam int TMR_MAX = (TIMEOUT > RST_CYC) ? TIMEOUT : RST_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;

  localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(RST_CYC - 1);
  localparam logic [TMR_W-1:0] RUN_LAST = TMR_W'(TIMEOUT - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOAD    = 3'd1;
  localparam logic [2:0] RST_DUT = 3'd2;
  localparam logic [2:0] RUN     = 3'd3;
  localparam logic [2:0] REPORT  = 3'd4;

  logic [2:0]         state;
  logic [TMR_W-1:0]   tmr;
  logic [NONCE_W-1:0] nonce_exp;
  logic [ENT_W-1:0]   fifo_head;
  logic               fifo_empty;
  logic               fifo_full;
  logic               fifo_push;
  logic               fifo_pop;

  assign job_ready = !fifo_full && !reset;
  assign fifo_push = job_valid && job_ready;
  assign fifo_pop  = (state == LOAD);

  secuenciador_trabajos_fifo #(
    .W     (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   ({job_num, job_target, job_nonce_exp}),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // The core only sees reset released while a job is running or being reported.
  assign dut_reset_L = (state == RUN) || (state == REPORT);
  assign res_valid   = (state == REPORT);
  assign idle        = (state == IDLE) && fifo_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      tmr          <= '0;
      num_entradas <= '0;
      target       <= '0;
      nonce_exp    <= '0;
      res_pass     <= 1'b0;
      res_timeout  <= 1'b0;
      res_nonce    <= '0;
      res_bounty   <= '0;
      pass_cnt     <= '0;
      fail_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) state <= LOAD;
        end
        LOAD: begin
          {num_entradas, target, nonce_exp} <= fifo_head;
          tmr   <= '0;
          state <= RST_DUT;
        end
        RST_DUT: begin
          if (tmr == RST_LAST) begin
            tmr   <= '0;
            state <= RUN;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        RUN: begin
          // A fin on the last allowed cycle still counts as a normal completion.
          if (fin) begin
            res_nonce   <= nonce_valido_out;
            res_bounty  <= bounty_out;
            res_pass    <= (nonce_valido_out == nonce_exp);
            res_timeout <= 1'b0;
            state       <= REPORT;
          end else if (tmr == RUN_LAST) begin
            res_nonce   <= '0;
            res_bounty  <= '0;
            res_pass    <= 1'b0;
            res_timeout <= 1'b1;
            state       <= REPORT;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        REPORT: begin
          if (res_ready) begin
            if (res_pass) begin
              if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
            end else begin
              if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
            end
            state <= fifo_empty ? IDLE : LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
